// File: rtl/led_frame_capture_if.sv
// Bus between the pixel mapper / LED serializer and the ping-pong LED frame buffer.
interface led_frame_capture_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [15:0]           pixel_data_i;
  logic                  vsync_i;
  logic [ADDR_WIDTH-1:0] led_strip_address_i;
  logic                  led_strip_address_valid_i;
  logic [ADDR_WIDTH-1:0] rd_address_i;
  logic [23:0]           rd_data_o;
  logic                  rd_busy_i;
  logic                  frame_ready_o;
  logic [7:0]            dropped_count_o;
  logic                  error_o;

  modport master (
    output pixel_data_i, vsync_i, led_strip_address_i, led_strip_address_valid_i,
    output rd_address_i, rd_busy_i,
    input  rd_data_o, frame_ready_o, dropped_count_o, error_o
  );

  modport slave (
    input  pixel_data_i, vsync_i, led_strip_address_i, led_strip_address_valid_i,
    input  rd_address_i, rd_busy_i,
    output rd_data_o, frame_ready_o, dropped_count_o, error_o
  );
endinterface

// File: rtl/led_frame_capture.sv
// Captures mapped LCD pixels as GRB into the back bank of a ping-pong LED buffer;
// swaps banks on vsync rising edge, deferring while the serializer is busy.
module led_frame_capture #(
  parameter int ADDR_WIDTH = 10,
  parameter int LED_COUNT  = 319
) (
  input logic               pixel_clk_i,
  input logic               reset_i,
  led_frame_capture_if.slave bus
);
  localparam int IDX_W = $clog2(LED_COUNT);
  localparam logic [ADDR_WIDTH-1:0] LIMIT = ADDR_WIDTH'(LED_COUNT);

  typedef enum logic {CAPTURE, PENDING} state_t;

  state_t            state;
  logic              bank_sel;
  logic              vsync_q;
  logic              vs_edge;
  logic              wr_vld_q;
  logic              wr_bank_q;
  logic [IDX_W-1:0]  wr_idx_q;
  logic [23:0]       wr_data_q;
  logic              wr_in_range;
  logic [23:0]       grb;
  logic [4:0]        r5, b5;
  logic [5:0]        g5;

  logic [23:0] mem [2][LED_COUNT];

  assign r5 = bus.pixel_data_i[15:11];
  assign g5 = bus.pixel_data_i[10:5];
  assign b5 = bus.pixel_data_i[4:0];
  assign grb = {g5, g5[5:4], r5, r5[4:2], b5, b5[4:2]};

  assign wr_in_range = bus.led_strip_address_i < LIMIT;
  assign vs_edge     = bus.vsync_i & ~vsync_q;

  // Input stage latches the back bank of this cycle, so a write racing a swap
  // still lands in the bank that was back when it was sampled.
  always_ff @(posedge pixel_clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_vld_q    <= 1'b0;
      wr_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      bus.error_o <= 1'b0;
    end else begin
      wr_vld_q  <= bus.led_strip_address_valid_i & wr_in_range;
      wr_bank_q <= ~bank_sel;
      wr_idx_q  <= bus.led_strip_address_i[IDX_W-1:0];
      wr_data_q <= grb;
      if (bus.led_strip_address_valid_i && !wr_in_range)
        bus.error_o <= 1'b1;
    end
  end

  always_ff @(posedge pixel_clk_i) begin
    if (wr_vld_q)
      mem[wr_bank_q][wr_idx_q] <= wr_data_q;
  end

  always_ff @(posedge pixel_clk_i or posedge reset_i) begin
    if (reset_i)
      bus.rd_data_o <= '0;
    else if (bus.rd_address_i < LIMIT)
      bus.rd_data_o <= mem[bank_sel][bus.rd_address_i[IDX_W-1:0]];
    else
      bus.rd_data_o <= '0;
  end

  always_ff @(posedge pixel_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state               <= CAPTURE;
      bank_sel            <= 1'b0;
      vsync_q             <= 1'b0;
      bus.frame_ready_o   <= 1'b0;
      bus.dropped_count_o <= '0;
    end else begin
      vsync_q           <= bus.vsync_i;
      bus.frame_ready_o <= 1'b0;
      case (state)
        CAPTURE: begin
          if (vs_edge) begin
            if (!bus.rd_busy_i) begin
              bank_sel          <= ~bank_sel;
              bus.frame_ready_o <= 1'b1;
            end else begin
              state <= PENDING;
            end
          end
        end
        PENDING: begin
          // A release wins over a coincident edge: that edge is the swap, not a drop.
          if (!bus.rd_busy_i) begin
            bank_sel          <= ~bank_sel;
            bus.frame_ready_o <= 1'b1;
            state             <= CAPTURE;
          end else if (vs_edge && bus.dropped_count_o != 8'hFF) begin
            bus.dropped_count_o <= bus.dropped_count_o + 8'd1;
          end
        end
        default: state <= CAPTURE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_frame_capture.sv
// Directed scoreboard bench for led_frame_capture: read expectations are queued
// at issue time and popped by a monitor when the read data is presented.
module tb_led_frame_capture;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  led_frame_capture_if #(.ADDR_WIDTH(10)) bus();

  led_frame_capture #(.ADDR_WIDTH(10), .LED_COUNT(319)) dut (
    .pixel_clk_i(clk),
    .reset_i(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;
  int fr_cnt = 0;
  logic [23:0] rd_q[$];
  string       rd_name_q[$];
  logic rd_chk = 1'b0;
  logic rd_pend = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Read monitor: data appears one cycle after the address is presented.
  always @(posedge clk or posedge rst) begin
    if (rst) rd_pend <= 1'b0;
    else     rd_pend <= rd_chk;
  end

  always @(negedge clk) begin
    if (bus.frame_ready_o === 1'b1) fr_cnt++;
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        n_chk++;
        $display("FAIL rd_unexpected: got %0h expected no read", bus.rd_data_o);
      end else begin
        logic [23:0] e;
        string nm;
        e  = rd_q.pop_front();
        nm = rd_name_q.pop_front();
        check(nm, {8'h0, bus.rd_data_o}, {8'h0, e});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [9:0] a, input logic [15:0] pix);
    bus.led_strip_address_i       = a;
    bus.pixel_data_i              = pix;
    bus.led_strip_address_valid_i = 1'b1;
    tick();
    bus.led_strip_address_valid_i = 1'b0;
  endtask

  task automatic rd(input string name, input logic [9:0] a, input logic [23:0] exp);
    bus.rd_address_i = a;
    rd_q.push_back(exp);
    rd_name_q.push_back(name);
    rd_chk = 1'b1;
    tick();
    rd_chk = 1'b0;
  endtask

  // vsync pulse; checks frame_ready during the cycle after the edge and the one after.
  task automatic vs_pulse(input string name, input logic exp_fr);
    bus.vsync_i = 1'b1;
    tick();
    check({name, "_fr"}, {31'h0, bus.frame_ready_o}, {31'h0, exp_fr});
    bus.vsync_i = 1'b0;
    tick();
    check({name, "_fr_end"}, {31'h0, bus.frame_ready_o}, 32'h0);
  endtask

  initial begin
    int fr0;
    bus.pixel_data_i = '0;
    bus.vsync_i = 1'b0;
    bus.led_strip_address_i = '0;
    bus.led_strip_address_valid_i = 1'b0;
    bus.rd_address_i = '0;
    bus.rd_busy_i = 1'b0;

    #2;
    check("rst_rd_data", {8'h0, bus.rd_data_o}, 32'h0);
    check("rst_frame_ready", {31'h0, bus.frame_ready_o}, 32'h0);
    check("rst_dropped", {24'h0, bus.dropped_count_o}, 32'h0);
    check("rst_error", {31'h0, bus.error_o}, 32'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Colour expansion into bank 1, then swap
    wr(0, 16'hF800);
    wr(1, 16'h07E0);
    wr(2, 16'h001F);
    wr(3, 16'h8410);
    vs_pulse("colour_swap", 1'b1);
    rd("colour_red", 0, 24'h00FF00);
    rd("colour_green", 1, 24'hFF0000);
    rd("colour_blue", 2, 24'h0000FF);
    rd("colour_mid", 3, 24'h828484);

    // Swap isolation: front=1, back=0
    wr(10, 16'hFFFF);
    vs_pulse("iso_swap_a", 1'b1);
    rd("iso_white", 10, 24'hFFFFFF);
    wr(10, 16'h0000);
    tick();
    rd("iso_still_white", 10, 24'hFFFFFF);
    vs_pulse("iso_swap_b", 1'b1);
    rd("iso_black", 10, 24'h000000);

    // Busy deferral (front=1 -> 0)
    bus.rd_busy_i = 1'b1;
    vs_pulse("defer_edge", 1'b0);
    tick(); tick();
    check("defer_hold_fr", {31'h0, bus.frame_ready_o}, 32'h0);
    bus.rd_busy_i = 1'b0;
    check("defer_m_fr", {31'h0, bus.frame_ready_o}, 32'h0);
    tick();
    check("defer_m1_fr", {31'h0, bus.frame_ready_o}, 32'h1);
    tick();
    check("defer_m2_fr", {31'h0, bus.frame_ready_o}, 32'h0);
    check("defer_dropped", {24'h0, bus.dropped_count_o}, 32'h0);
    rd("defer_bank0", 10, 24'hFFFFFF);

    // Drop counting (front=0 -> 1)
    fr0 = fr_cnt;
    bus.rd_busy_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      bus.vsync_i = 1'b1; tick();
      bus.vsync_i = 1'b0; tick();
      if (i == 99)  check("drop_100", {24'h0, bus.dropped_count_o}, 32'd99);
      if (i == 255) check("drop_256", {24'h0, bus.dropped_count_o}, 32'd255);
    end
    check("drop_sat", {24'h0, bus.dropped_count_o}, 32'd255);
    check("drop_no_fr", fr_cnt - fr0, 32'd0);
    bus.rd_busy_i = 1'b0;
    tick();
    check("drop_release_fr", {31'h0, bus.frame_ready_o}, 32'h1);
    tick(); tick(); tick();
    check("drop_one_fr", fr_cnt - fr0, 32'd1);
    rd("drop_bank1", 10, 24'h000000);

    // Boundary writes into back bank 0
    wr(318, 16'h001F);
    check("err_before", {31'h0, bus.error_o}, 32'h0);
    wr(319, 16'hFFFF);
    check("err_set", {31'h0, bus.error_o}, 32'h1);
    bus.led_strip_address_i = 10'd5;
    bus.pixel_data_i = 16'h07E0;
    bus.led_strip_address_valid_i = 1'b1;
    bus.vsync_i = 1'b1;
    tick();
    bus.led_strip_address_valid_i = 1'b0;
    bus.vsync_i = 1'b0;
    check("edge_wr_fr", {31'h0, bus.frame_ready_o}, 32'h1);
    tick();
    rd("edge_wr_addr5", 5, 24'hFF0000);
    rd("bound_318", 318, 24'h0000FF);
    rd("bound_319", 319, 24'h000000);
    rd("bound_10_intact", 10, 24'hFFFFFF);
    tick(); tick();
    check("err_sticky", {31'h0, bus.error_o}, 32'h1);

    // Async reset while PENDING
    bus.rd_busy_i = 1'b1;
    vs_pulse("pend_edge", 1'b0);
    tick();
    #2 rst = 1'b1;
    #1;
    check("areset_fr", {31'h0, bus.frame_ready_o}, 32'h0);
    check("areset_dropped", {24'h0, bus.dropped_count_o}, 32'h0);
    check("areset_error", {31'h0, bus.error_o}, 32'h0);
    check("areset_rd_data", {8'h0, bus.rd_data_o}, 32'h0);
    tick();
    bus.rd_busy_i = 1'b0;
    rst = 1'b0;
    fr0 = fr_cnt;
    tick(); tick(); tick();
    check("areset_abandoned", fr_cnt - fr0, 32'd0);
    vs_pulse("areset_swap", 1'b1);
    rd("areset_bank1_a0", 0, 24'h00FF00);
    rd("areset_bank1_a10", 10, 24'h000000);
    tick(); tick();

    check("scoreboard_empty", rd_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
